// File: rtl/sparc_muldiv_unit.sv
// Iterative multiply/divide unit for the SPARCv8 integer execution stage.
// Performs UMUL/SMUL (radix-2 shift-add) and UDIV/SDIV (restoring division
// of {Y, r1} by r2) over a start/busy/done handshake.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   op              00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV
//   set_cc          update ICC on completion
//   r1, r2, y_in    operands; dividend is {y_in, r1}
//   busy, done      in-progress level / one-cycle completion pulse
//   rd, y_out       result low half (or quotient) / product high half
//   y_we, icc_we    write enables, pulse with done
//   icc_out         NZVC
//   divide_by_zero  trap level, cleared by the next accepted start
module sparc_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] y_out,
  output logic             y_we,
  output logic [3:0]       icc_out,
  output logic             icc_we,
  output logic             divide_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(W2 + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             cc_q, cc_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [W2-1:0]    work_q, work_d; // {acc, multiplier} or dividend/quotient
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_q, rd_d, y_q, y_d;
  logic [3:0]       icc_q, icc_d;
  logic             y_we_q, y_we_d, icc_we_q, icc_we_d, done_q, done_d, dbz_q, dbz_d;

  // Operand preparation
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    dvd, dvd_mag;
  logic             in_sign;
  assign a_mag   = (op[0] && r1[WIDTH-1]) ? -r1 : r1;
  assign b_mag   = (op[0] && r2[WIDTH-1]) ? -r2 : r2;
  assign dvd     = {y_in, r1};
  assign dvd_mag = (op[0] && y_in[WIDTH-1]) ? -dvd : dvd;
  assign in_sign = op[0] & ((op[1] ? y_in[WIDTH-1] : r1[WIDTH-1]) ^ r2[WIDTH-1]);

  // One iteration step
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  assign mul_sum   = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {rem_q, work_q[W2-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  // When div_ge the true difference is below the divisor, so W bits suffice.
  assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

  // Result fix-up
  logic [W2-1:0]    res;
  logic             ovf, dbz;
  logic [WIDTH-1:0] div_rd, new_rd;
  assign res    = sign_q ? -work_q : work_q;
  assign ovf    = op_q[0] ? !((&res[W2-1:WIDTH-1]) || !(|res[W2-1:WIDTH-1]))
                          : |res[W2-1:WIDTH];
  assign div_rd = !ovf     ? res[WIDTH-1:0] :
                  !op_q[0] ? '1 :
                  sign_q   ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign new_rd = op_q[1] ? div_rd : res[WIDTH-1:0];
  assign dbz    = op_q[1] && (opb_q == '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cc_d     = cc_q;
    sign_d   = sign_q;
    opb_d    = opb_q;
    work_d   = work_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    y_d      = y_q;
    icc_d    = icc_q;
    dbz_d    = dbz_q;
    y_we_d   = 1'b0;
    icc_we_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          cc_d    = set_cc;
          sign_d  = in_sign;
          opb_d   = op[1] ? b_mag : a_mag;
          work_d  = op[1] ? dvd_mag : {{WIDTH{1'b0}}, b_mag};
          rem_d   = '0;
          cnt_d   = op[1] ? CW'(W2) : CW'(WIDTH);
          dbz_d   = 1'b0;
          state_d = (op[1] && (r2 == '0)) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (op_q[1]) begin
          work_d = {work_q[W2-2:0], div_ge};
          rem_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        end else begin
          work_d = {mul_sum, work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (dbz) begin
          dbz_d = 1'b1;
        end else begin
          rd_d = new_rd;
          if (!op_q[1]) begin
            y_d    = res[W2-1:WIDTH];
            y_we_d = 1'b1;
          end
          if (cc_q) begin
            icc_d    = {new_rd[WIDTH-1], new_rd == '0, op_q[1] & ovf, 1'b0};
            icc_we_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cc_q     <= 1'b0;
      sign_q   <= 1'b0;
      opb_q    <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      y_q      <= '0;
      icc_q    <= '0;
      y_we_q   <= 1'b0;
      icc_we_q <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cc_q     <= cc_d;
      sign_q   <= sign_d;
      opb_q    <= opb_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      y_q      <= y_d;
      icc_q    <= icc_d;
      y_we_q   <= y_we_d;
      icc_we_q <= icc_we_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign rd             = rd_q;
  assign y_out          = y_q;
  assign y_we           = y_we_q;
  assign icc_out        = icc_q;
  assign icc_we         = icc_we_q;
  assign divide_by_zero = dbz_q;

endmodule

// File: doc/sparc_muldiv_unit.md
# sparc_muldiv_unit

Iterative, width-parametrised multiply/divide unit for the SPARCv8 integer execution stage. It performs UMUL, SMUL, UDIV and SDIV, with optional condition-code update, over a start/busy/done handshake. This frees the single-cycle ALU from wide combinational `*` and `/` operators. The Y register semantics are preserved: the product high half goes to Y, and the dividend is {Y, r1}.

## Interface
- `WIDTH`, 32: operand width W; the product and the dividend are 2W bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 2: 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV.
- `set_cc` in 1: the cc variant of the op (updates ICC).
- `r1` in W: multiplicand, or low half of the dividend.
- `r2` in W: multiplier, or divisor.
- `y_in` in W: current Y, the high half of the dividend.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse; results are valid.
- `rd` out W: result (product low half, or quotient).
- `y_out` out W: product high half.
- `y_we` out 1: pulses with `done` on multiply ops.
- `icc_out` out 4: NZVC.
- `icc_we` out 1: pulses with `done` when `set_cc`=1 and there is no trap.
- `divide_by_zero` out 1: trap flag.

## Operation
- Reset value of every output is 0; the FSM resets to IDLE.
- FSM states are IDLE, CALC and FIX.
- **IDLE.** `start`=1 latches `op`, `set_cc`, `r1`, `r2` and `y_in`. The unit also latches operand magnitudes and the result sign (sign = XOR of the operand signs; for divide, the dividend sign is `y_in`[W-1]). On entry it:
  - clears `divide_by_zero`;
  - loads the iteration counter with W (multiply) or 2W (divide);
  - moves to CALC.
- **Divide-by-zero.** A divide with `r2`==0 instead goes to FIX directly, skipping CALC. FIX then sets `divide_by_zero`=1 and pulses `done`. `rd`, `y_out` and `icc_out` hold their previous values; `y_we` and `icc_we` stay 0.
- **CALC, multiply.** Radix-2 shift-add on unsigned magnitudes, one multiplier bit per cycle, into a 2W-bit accumulator.
- **CALC, divide.** Restoring division of the 2W-bit dividend magnitude by the W-bit divisor magnitude, producing one quotient bit per cycle (2W-bit quotient). The remainder is discarded.
- **CALC exit.** When the counter reaches 0, go to FIX.
- **FIX, sign fix.** For signed ops with a negative sign, negate the 2W-bit result. Signed quotients truncate toward zero.
- **FIX, multiply results.** {`y_out`, `rd`} = product; `y_we`=1.
- **FIX, UDIV overflow.** Overflow when quotient[2W-1:W] != 0; then `rd` = all ones.
- **FIX, SDIV overflow.** Overflow when quotient[2W-1:W-1] is neither all-0 nor all-1. Then `rd` = 2^(W-1)-1 if the true quotient is positive, or -2^(W-1) if negative.
- **FIX, divide results.** With no overflow, `rd` = quotient[W-1:0].
- **ICC when `set_cc`=1:**
  - N = `rd`[W-1];
  - Z = (`rd`==0);
  - V = overflow on divide, 0 on multiply;
  - C = 0.
- **ICC when `set_cc`=0:** `icc_out` holds and `icc_we`=0.
- **FIX exit.** Pulse `done` and return to IDLE.
- `divide_by_zero` is a level: it stays 1 until the next accepted `start` or reset.

## Timing
- Call the edge that samples `start` edge 0.
- `busy`=1 from edge 0 until the edge that asserts `done`; `busy` and `done` are never both 1.
- `done` is high for exactly one cycle after edge W+1 (multiply), 2W+1 (divide) or 1 (divide-by-zero).
- `rd`, `y_out` and `icc_out` are registered at the FIX edge and hold until the next FIX.
- `start` while `busy`=1 is ignored, with no queuing.
- A new `start` may be asserted in the same cycle `done` is high; it is accepted, giving back-to-back operation.
- Input changes after edge 0 have no effect on the operation in flight.
- `rst` low at any time, including mid-CALC, clears all state and outputs immediately; no `done` is produced for the aborted operation.

## Test plan
- **UMUL max.** UMUL, `r1`=0xFFFFFFFF, `r2`=2, W=32 → `done` 33 cycles after edge 0; `y_out`=0x00000001, `rd`=0xFFFFFFFE, `y_we`=1.
- **SMUL negative result.** SMULcc, `r1`=-3, `r2`=5 → `y_out`=0xFFFFFFFF, `rd`=0xFFFFFFF1, `icc_out`=1000, `icc_we`=1.
- **UDIV normal and overflow.**
  - UDIVcc, `y_in`=0, `r1`=100, `r2`=7 → `rd`=14, `icc`=0000, `done` 65 cycles after edge 0.
  - `y_in`=1, `r1`=0, `r2`=1 → `rd`=0xFFFFFFFF, `icc`=1010.
- **SDIV normal and overflow.**
  - SDIVcc, `y_in`=0xFFFFFFFF, `r1`=0xFFFFFF9C, `r2`=7 → `rd`=0xFFFFFFF2 (-14), `icc`=1000.
  - `y_in`=0, `r1`=0x80000000, `r2`=1 → `rd`=0x7FFFFFFF, `icc`=0010.
- **Divide-by-zero.** UDIVcc with `r2`=0 → `done` 1 cycle after edge 0, `divide_by_zero`=1, `icc_we`=0, `rd` unchanged. The next accepted `start` clears the flag.
- **Handshake and reset.**
  - `start` pulsed during `busy` → ignored; the result matches the first operation.
  - `start` asserted in the `done` cycle → accepted.
  - `rst` low mid-CALC → all outputs 0, `busy`=0, and no `done` pulse.
